// File: rtl/powerup_spawner.sv
// Schedules falling power-up drops. A free-running Galois LFSR supplies both the
// random extra delay between power-ups and the X column each one spawns from.
module powerup_spawner #(
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          MIN_DELAY  = 120,
  parameter logic [7:0]  DELAY_MASK = 8'hFF,
  parameter int          X_MIN      = 10,
  parameter int          X_MAX      = 620,
  parameter int          SPAWN_TMO  = 4
) (
  input  logic       i_frame_clk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic       i_powerup_exists,
  input  logic       i_got_powerup,
  output logic       o_generate_powerup,
  output logic [9:0] o_powerup_startpos,
  output logic [7:0] o_collected_count,
  output logic [1:0] o_spawner_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SPAWN  = 2'd2,
    ACTIVE = 2'd3
  } spawnState_t;

  // An all-zero seed would lock the LFSR at zero forever, so it is replaced by 1.
  localparam logic [15:0] SEED_EFF    = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;
  localparam logic [9:0]  X_MIN_V     = 10'(X_MIN);
  localparam logic [9:0]  SPAN        = 10'(X_MAX - X_MIN);
  localparam logic [9:0]  SPAN_P1     = 10'(X_MAX - X_MIN + 1);
  localparam logic [10:0] MIN_DELAY_V = 11'(MIN_DELAY);
  localparam logic [7:0]  TMO_INIT    = 8'(SPAWN_TMO - 1);

  spawnState_t r_state;
  logic [15:0] r_lfsr;
  logic [10:0] r_delayCnt;
  logic [7:0]  r_timeout;
  logic        r_generate;
  logic [9:0]  r_startPos;
  logic [7:0]  r_collected;

  logic [15:0] w_lfsrNext;
  logic [10:0] w_reload;
  logic [9:0]  w_raw;
  logic [9:0]  w_posOff;
  logic [9:0]  w_pos;

  // Span+1 is at least 512, so a single wrap-around subtraction keeps the column in range.
  always_comb begin
    w_lfsrNext = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
    w_reload   = MIN_DELAY_V + {3'b000, r_lfsr[15:8] & DELAY_MASK};
    w_raw      = r_lfsr[9:0];
    w_posOff   = (w_raw > SPAN) ? (w_raw - SPAN_P1) : w_raw;
    w_pos      = X_MIN_V + w_posOff;
  end

  always_ff @(posedge i_frame_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_lfsr      <= SEED_EFF;
      r_delayCnt  <= '0;
      r_timeout   <= '0;
      r_generate  <= 1'b0;
      r_startPos  <= X_MIN_V;
      r_collected <= '0;
    end else begin
      r_lfsr <= w_lfsrNext;
      if (i_got_powerup && (r_collected != 8'hFF)) begin
        r_collected <= r_collected + 8'd1;
      end
      if (!i_enable) begin
        r_state    <= IDLE;
        r_generate <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state    <= WAIT;
            r_delayCnt <= w_reload;
          end
          // With the counter expired, a lingering power-up holds us here until it is gone.
          WAIT: begin
            if (r_delayCnt != 11'd0) begin
              r_delayCnt <= r_delayCnt - 11'd1;
            end else if (!i_powerup_exists) begin
              r_state    <= SPAWN;
              r_startPos <= w_pos;
              r_generate <= 1'b1;
              r_timeout  <= TMO_INIT;
            end
          end
          SPAWN: begin
            if (i_powerup_exists) begin
              r_state    <= ACTIVE;
              r_generate <= 1'b0;
            end else if (r_timeout == 8'd0) begin
              r_state    <= WAIT;
              r_delayCnt <= w_reload;
              r_generate <= 1'b0;
            end else begin
              r_timeout <= r_timeout - 8'd1;
            end
          end
          ACTIVE: begin
            if (!i_powerup_exists) begin
              r_state    <= WAIT;
              r_delayCnt <= w_reload;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_generate_powerup = r_generate;
  assign o_powerup_startpos = r_startPos;
  assign o_collected_count  = r_collected;
  assign o_spawner_state    = r_state;

endmodule
